usb_device_rw_responder: RTL and testbench

//  Device-side end of the host read/write flow: a flash-style endpoint behind the USB device

---
 rtl/usb_device_rw_responder_if.sv | 31 +++
 rtl/usb_device_rw_responder.sv | 164 ++++++++++++++++
 tb/tb_usb_device_rw_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_device_rw_responder_if.sv
// Token/packet inputs from the USB device decoder and DATA/handshake requests to the encoder.
interface usb_device_rw_responder_if;
    logic        tok_valid;
    logic [3:0]  tok_pid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic        data_valid;
    logic        data_ok;
    logic [63:0] data_in;
    logic        host_ack;
    logic        tx_ready;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic        hs_valid;
    logic        hs_ack;
    logic [15:0] page_reg;
    logic        txn_done;
    logic        txn_write;

    modport master (
        output tok_valid, tok_pid, tok_addr, tok_endp,
        output data_valid, data_ok, data_in, host_ack, tx_ready,
        input  tx_valid, tx_data, hs_valid, hs_ack, page_reg, txn_done, txn_write
    );

    modport slave (
        input  tok_valid, tok_pid, tok_addr, tok_endp,
        input  data_valid, data_ok, data_in, host_ack, tx_ready,
        output tx_valid, tx_data, hs_valid, hs_ack, page_reg, txn_done, txn_write
    );
endinterface

// File: rtl/usb_device_rw_responder.sv
// Flash-style USB endpoint: page select on ADDR_ENDP, 64-bit word write/read on DATA_ENDP.
module usb_device_rw_responder #(
    parameter logic [6:0] DEV_ADDR  = 7'd5,
    parameter logic [3:0] ADDR_ENDP = 4'd4,
    parameter logic [3:0] DATA_ENDP = 4'd8,
    parameter int         DEPTH     = 16,
    parameter int         TIMEOUT   = 255
) (
    input logic                  clk,
    input logic                  rst_b,
    usb_device_rw_responder_if.slave bus
);
    localparam int         CNT_W   = $clog2(TIMEOUT + 1);
    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] PID_OUT = 4'b0001;
    localparam logic [3:0] PID_IN  = 4'b1001;

    typedef enum logic [2:0] {IDLE, GET_PAGE, PAGE_SET, WR_DATA, RD_SEND, RD_ACK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tx_valid_q, tx_valid_d;
    logic [63:0]        tx_data_q, tx_data_d;
    logic               hs_valid_q, hs_valid_d;
    logic               hs_ack_q, hs_ack_d;
    logic [15:0]        page_reg_q, page_reg_d;
    logic               txn_done_q, txn_done_d;
    logic               txn_write_q, txn_write_d;
    logic               mem_we;
    logic [63:0]        mem_q [DEPTH];

    logic               tok_ok, out_addr, out_data, in_data, timed_out, page_in_range;
    logic [IDX_W-1:0]   mem_idx;

    assign tok_ok = bus.tok_valid && (bus.tok_addr == DEV_ADDR)
                 && ((bus.tok_endp == ADDR_ENDP) || (bus.tok_endp == DATA_ENDP))
                 && ((bus.tok_pid == PID_OUT) || (bus.tok_pid == PID_IN));
    assign out_addr      = tok_ok && (bus.tok_pid == PID_OUT) && (bus.tok_endp == ADDR_ENDP);
    assign out_data      = tok_ok && (bus.tok_pid == PID_OUT) && (bus.tok_endp == DATA_ENDP);
    assign in_data       = tok_ok && (bus.tok_pid == PID_IN)  && (bus.tok_endp == DATA_ENDP);
    assign timed_out     = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign page_in_range = (bus.data_in[15:0] < 16'(DEPTH));
    assign mem_idx       = page_reg_q[IDX_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        hs_valid_d  = 1'b0;
        hs_ack_d    = 1'b0;
        page_reg_d  = page_reg_q;
        txn_done_d  = 1'b0;
        txn_write_d = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (out_addr) state_d = GET_PAGE;
            end
            GET_PAGE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.data_valid) begin
                    hs_valid_d = 1'b1;
                    if (bus.data_ok && page_in_range) begin
                        hs_ack_d   = 1'b1;
                        page_reg_d = bus.data_in[15:0];
                        state_d    = PAGE_SET;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timed_out) begin
                    state_d = IDLE;
                end
            end
            PAGE_SET: begin
                if (out_data) begin
                    state_d = WR_DATA;
                end else if (in_data) begin
                    state_d    = RD_SEND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = mem_q[mem_idx];
                end else if (out_addr) begin
                    state_d = GET_PAGE;
                end
            end
            WR_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.data_valid) begin
                    hs_valid_d = 1'b1;
                    if (bus.data_ok) begin
                        hs_ack_d    = 1'b1;
                        mem_we      = 1'b1;
                        txn_done_d  = 1'b1;
                        txn_write_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = PAGE_SET;
                    end
                end else if (timed_out) begin
                    state_d = PAGE_SET;
                end
            end
            RD_SEND: begin
                if (tx_valid_q && bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = RD_ACK;
                end
            end
            RD_ACK: begin
                cnt_d = cnt_q + CNT_W'(1);
                // host_ack outranks both a retry IN and the timeout in the same cycle
                if (bus.host_ack) begin
                    txn_done_d = 1'b1;
                    state_d    = IDLE;
                end else if (in_data) begin
                    state_d    = RD_SEND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = mem_q[mem_idx];
                end else if (timed_out) begin
                    state_d = PAGE_SET;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            hs_valid_q  <= 1'b0;
            hs_ack_q    <= 1'b0;
            page_reg_q  <= '0;
            txn_done_q  <= 1'b0;
            txn_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            hs_valid_q  <= hs_valid_d;
            hs_ack_q    <= hs_ack_d;
            page_reg_q  <= page_reg_d;
            txn_done_q  <= txn_done_d;
            txn_write_q <= txn_write_d;
        end
    end

    // Memory survives reset; a write coinciding with reset is dropped with the rest of the txn.
    always_ff @(posedge clk) begin
        if (rst_b && mem_we) mem_q[mem_idx] <= bus.data_in;
    end

    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.hs_valid  = hs_valid_q;
    assign bus.hs_ack    = hs_ack_q;
    assign bus.page_reg  = page_reg_q;
    assign bus.txn_done  = txn_done_q;
    assign bus.txn_write = txn_write_q;
endmodule

// File: tb/tb_usb_device_rw_responder.sv
// Randomized bench for usb_device_rw_responder against a transaction-level model of pages and memory.
module tb_usb_device_rw_responder;
    localparam logic [6:0] DEV     = 7'd5;
    localparam logic [3:0] PID_OUT = 4'b0001;
    localparam logic [3:0] PID_IN  = 4'b1001;
    localparam int         TIMEOUT = 255;
    localparam int         DEPTH   = 16;

    logic clk = 1'b0;
    logic rst_b;
    int   tests_run = 0;
    int   failures  = 0;

    logic [63:0] mem_model [DEPTH];
    bit          known [DEPTH];
    logic [15:0] model_page;
    bit          page_set;

    usb_device_rw_responder_if bus();

    usb_device_rw_responder dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic tv, input logic [3:0] pid, input logic [6:0] addr,
                                 input logic [3:0] endp, input logic dv, input logic ok,
                                 input logic [63:0] d, input logic ha);
        bus.tok_valid  = tv;
        bus.tok_pid    = pid;
        bus.tok_addr   = addr;
        bus.tok_endp   = endp;
        bus.data_valid = dv;
        bus.data_ok    = ok;
        bus.data_in    = d;
        bus.host_ack   = ha;
        step();
        bus.tok_valid  = 1'b0;
        bus.data_valid = 1'b0;
        bus.host_ack   = 1'b0;
    endtask

    task automatic token(input logic [3:0] pid, input logic [3:0] endp);
        applyStimulus(1'b1, pid, DEV, endp, 1'b0, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            checkOutput("idle_quiet", {bus.hs_valid, bus.txn_done}, 0);
        end
    endtask

    task automatic model_reset();
        model_page = 16'h0;
        page_set   = 1'b0;
    endtask

    // A phase that waits TIMEOUT or more cycles without its event has already been abandoned.
    task automatic set_page(input logic [63:0] p, input bit ok, input int gap);
        bit exp_ack;
        token(PID_OUT, 4'd4);
        checkOutput("tok_no_hs", bus.hs_valid, 0);
        idle(gap);
        applyStimulus(1'b0, 4'h0, 7'h0, 4'h0, 1'b1, ok, p, 1'b0);
        if (gap >= TIMEOUT) begin
            checkOutput("gp_timeout_hs", bus.hs_valid, 0);
            page_set = 1'b0;
        end else begin
            exp_ack = ok && (p[15:0] < 16'(DEPTH));
            checkOutput("gp_hs_valid", bus.hs_valid, 1);
            checkOutput("gp_hs_ack", bus.hs_ack, exp_ack);
            if (exp_ack) model_page = p[15:0];
            page_set = exp_ack;
        end
        checkOutput("page_reg", bus.page_reg, model_page);
    endtask

    task automatic write_word(input logic [63:0] d, input bit ok, input int gap);
        token(PID_OUT, 4'd8);
        idle(gap);
        applyStimulus(1'b0, 4'h0, 7'h0, 4'h0, 1'b1, ok, d, 1'b0);
        if (gap >= TIMEOUT) begin
            checkOutput("wr_timeout_hs", bus.hs_valid, 0);
        end else begin
            checkOutput("wr_hs_valid", bus.hs_valid, 1);
            checkOutput("wr_hs_ack", bus.hs_ack, ok);
            checkOutput("wr_txn_done", bus.txn_done, ok);
            if (ok) begin
                checkOutput("wr_txn_write", bus.txn_write, 1);
                mem_model[model_page[3:0]] = d;
                known[model_page[3:0]]     = 1'b1;
                page_set                   = 1'b0;
            end
        end
    endtask

    task automatic read_word(input int delay, input int gap);
        logic [63:0] exp;
        exp = mem_model[model_page[3:0]];
        token(PID_IN, 4'd8);
        checkOutput("rd_tx_valid", bus.tx_valid, 1);
        checkOutput("rd_tx_data", bus.tx_data, exp);
        for (int i = 0; i < delay; i++) begin
            step();
            checkOutput("rd_hold_valid", bus.tx_valid, 1);
            checkOutput("rd_hold_data", bus.tx_data, exp);
        end
        bus.tx_ready = 1'b1;
        step();
        bus.tx_ready = 1'b0;
        checkOutput("rd_tx_drop", bus.tx_valid, 0);
        idle(gap);
        applyStimulus(1'b0, 4'h0, 7'h0, 4'h0, 1'b0, 1'b0, 64'h0, 1'b1);
        if (gap >= TIMEOUT) begin
            checkOutput("rd_late_ack", bus.txn_done, 0);
        end else begin
            checkOutput("rd_txn_done", bus.txn_done, 1);
            checkOutput("rd_txn_write", bus.txn_write, 0);
            page_set = 1'b0;
        end
    endtask

    task automatic invalid_token();
        logic [6:0] addr;
        logic [3:0] endp;
        logic [3:0] pid;
        int         kind;
        kind = $urandom_range(0, 2);
        addr = DEV;
        endp = ($urandom_range(0, 1) == 0) ? 4'd4 : 4'd8;
        pid  = ($urandom_range(0, 1) == 0) ? PID_OUT : PID_IN;
        if (kind == 0) begin
            addr = 7'($urandom_range(0, 127));
            if (addr == DEV) addr = 7'd6;
        end else if (kind == 1) begin
            endp = 4'($urandom_range(0, 15));
            if (endp == 4'd4 || endp == 4'd8) endp = 4'd2;
        end else begin
            pid = 4'($urandom_range(0, 15));
            if (pid == PID_OUT || pid == PID_IN) pid = 4'b1101;
        end
        applyStimulus(1'b1, pid, addr, endp, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("bad_tok_quiet", {bus.tx_valid, bus.hs_valid}, 0);
    endtask

    initial begin
        logic [63:0] rnd;
        int          r;
        bus.tok_valid  = 1'b0;
        bus.tok_pid    = 4'h0;
        bus.tok_addr   = 7'h0;
        bus.tok_endp   = 4'h0;
        bus.data_valid = 1'b0;
        bus.data_ok    = 1'b0;
        bus.data_in    = 64'h0;
        bus.host_ack   = 1'b0;
        bus.tx_ready   = 1'b0;
        rst_b          = 1'b0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        model_reset();
        step();
        step();
        checkOutput("rst_tx_valid", bus.tx_valid, 0);
        checkOutput("rst_tx_data", bus.tx_data, 0);
        checkOutput("rst_hs", {bus.hs_valid, bus.hs_ack}, 0);
        checkOutput("rst_page_reg", bus.page_reg, 0);
        checkOutput("rst_txn", {bus.txn_done, bus.txn_write}, 0);
        rst_b = 1'b1;
        step();

        set_page(64'h3, 1'b1, 0);
        write_word(64'hDEADBEEF_CAFEF00D, 1'b1, 0);
        set_page(64'h3, 1'b1, 0);
        read_word(0, 0);

        set_page(64'h3, 1'b1, 1);
        write_word(64'h1111_2222_3333_4444, 1'b0, 2);
        read_word(1, 2);
        set_page(64'h3, 1'b1, 0);
        write_word(64'hDEADBEEF_CAFEF00D, 1'b1, 0);

        set_page(64'h0010, 1'b1, 0);
        token(PID_IN, 4'd8);
        checkOutput("range_no_tx", {bus.tx_valid, bus.hs_valid}, 0);
        step();
        checkOutput("range_no_tx_late", {bus.tx_valid, bus.hs_valid}, 0);

        set_page(64'h3, 1'b1, 0);
        read_word(0, TIMEOUT - 1);
        set_page(64'h3, 1'b1, 0);
        read_word(0, TIMEOUT);
        applyStimulus(1'b1, PID_IN, 7'd6, 4'd8, 1'b0, 1'b0, 64'h0, 1'b0);
        checkOutput("addr6_ignored", bus.tx_valid, 0);
        read_word(2, 0);

        set_page(64'h5, 1'b1, 0);
        write_word(64'h0123_4567_89AB_CDEF, 1'b1, TIMEOUT);
        write_word(64'h0123_4567_89AB_CDEF, 1'b1, TIMEOUT - 1);
        set_page(64'h7, 1'b1, TIMEOUT - 1);
        set_page(64'h9, 1'b1, TIMEOUT);
        token(PID_IN, 4'd8);
        checkOutput("gp_timeout_idle", bus.tx_valid, 0);

        set_page(64'h3, 1'b1, 0);
        token(PID_IN, 4'd8);
        checkOutput("pre_rst_tx_valid", bus.tx_valid, 1);
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        model_reset();
        checkOutput("midrst_tx_valid", bus.tx_valid, 0);
        checkOutput("midrst_page_reg", bus.page_reg, 0);
        token(PID_IN, 4'd8);
        checkOutput("midrst_idle", bus.tx_valid, 0);
        set_page(64'h3, 1'b1, 0);
        read_word(2, 1);

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (!page_set) begin
                if (r == 0) begin
                    invalid_token();
                end else begin
                    rnd = {$urandom, $urandom};
                    rnd[15:0] = 16'($urandom_range(0, 19));
                    if (r == 1) rnd[15:0] = 16'($urandom);
                    set_page(rnd, $urandom_range(0, 9) != 0, $urandom_range(0, 3));
                end
            end else if (r < 4 || (r < 7 && !known[model_page[3:0]])) begin
                write_word({$urandom, $urandom}, $urandom_range(0, 4) != 0, $urandom_range(0, 3));
            end else if (r < 7) begin
                read_word($urandom_range(0, 3), $urandom_range(0, 5));
            end else if (r < 8) begin
                set_page({48'h0, 16'($urandom_range(0, 17))}, 1'b1, 0);
            end else begin
                invalid_token();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
